// File: rtl/uart_rx.sv
// UART receiver: 16x (OVERSAMPLE) oversampled deserialiser, 5-8 data bits, optional parity, 1/2 stop bits.
// Optional 2-of-3 majority bit decision when UART_RX_MAJORITY_EN is defined.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic [3:0] data_len,
  input  logic       stop2,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       frame_err,
  output logic       rx_busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for rx_s low
  // START     | start bit, confirmed or rejected at mid-bit
  // DATA      | data bits shifted in LSB-first
  // PAR       | parity bit captured
  // STOP1     | first stop bit sampled
  // STOP2     | second stop bit sampled
  // DONE      | rx_done cycle, results visible
  // WAIT_HIGH | stop bit was low, wait for line to return high
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, DONE, WAIT_HIGH} state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  state_t        state;
  logic          sync1, rx_s;
  logic [TW-1:0] tick;
  logic [2:0]    bitcnt, len_m1;
  logic          par_en_l, par_type_l, stop2_l, len_bad_l;
  logic [7:0]    shreg;
  logic          par_bit, stop_bad;
  logic          sample, bit_val, exp_par, fin, fin_bad, len_ok;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // hist holds rx_s from the two ticks before the decision tick
  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) hist <= 2'b11;
    else      hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign sample  = (tick == TICK_MID);
  assign len_ok  = (data_len >= 4'd5) && (data_len <= 4'd8);
  // unused upper shreg bits are zero, so the 8-bit reduction covers exactly the received bits
  assign exp_par = len_bad_l ? 1'b0 : (par_type_l ? ^shreg : ~^shreg);

  always_comb begin
    fin     = sample && ((state == STOP1 && !stop2_l) || state == STOP2);
    fin_bad = ~bit_val | ((state == STOP2) & stop_bad);
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick       <= '0;
      bitcnt     <= 3'd0;
      len_m1     <= 3'd7;
      par_en_l   <= 1'b0;
      par_type_l <= 1'b0;
      stop2_l    <= 1'b0;
      len_bad_l  <= 1'b0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
      rx_err     <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state != IDLE) tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          tick    <= TW'(1);
          rx_busy <= 1'b1;
        end
        START: if (sample) begin
          if (bit_val) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state      <= DATA;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            len_m1     <= len_ok ? 3'(data_len - 4'd1) : 3'd7;
            len_bad_l  <= ~len_ok;
            par_en_l   <= parity_en;
            par_type_l <= parity_type;
            stop2_l    <= stop2;
          end
        end
        DATA: if (sample) begin
          shreg[bitcnt] <= bit_val;
          if (bitcnt == len_m1) state <= par_en_l ? PAR : STOP1;
          else                  bitcnt <= bitcnt + 3'd1;
        end
        PAR: if (sample) begin
          par_bit <= bit_val;
          state   <= STOP1;
        end
        STOP1: if (sample && stop2_l) begin
          stop_bad <= ~bit_val;
          state    <= STOP2;
        end
        STOP2: ;
        DONE: begin
          state <= frame_err ? WAIT_HIGH : IDLE;
          if (!frame_err) rx_busy <= 1'b0;
        end
        WAIT_HIGH: if (rx_s) begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        state     <= DONE;
        rx_done   <= 1'b1;
        rx_data   <= shreg;
        rx_err    <= par_en_l & (par_bit ^ exp_par);
        frame_err <= fin_bad;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-level line driver pushes the expected frame result,
// an independent monitor pops and compares on every rx_done.
module tb_uart_rx;
  localparam int OS = 16;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [3:0] data_len = 4'd8;
  logic       stop2 = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, rx_err, frame_err, rx_busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .rx_clk(rx_clk), .rst(rst), .rx(rx), .parity_en(parity_en), .parity_type(parity_type),
    .data_len(data_len), .stop2(stop2), .rx_data(rx_data), .rx_done(rx_done),
    .rx_err(rx_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 rx_clk = ~rx_clk;

  int unsigned cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge rx_clk) begin
    if (rx_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx_done actual=%0h required=none (cycle %0d)", rx_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", rx_data, mon_e.data);
        check("rx_err", rx_err, mon_e.perr);
        check("frame_err", frame_err, mon_e.ferr);
        check("done_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    hold(OS);
  endtask

  function automatic int nbits_of(input logic [3:0] len);
    return (len >= 5 && len <= 8) ? int'(len) : 8;
  endfunction

  // Parity bit the receiver expects for the data it will keep
  function automatic logic ref_parity(input logic [7:0] d, input logic [3:0] len, input logic ptype);
    int n = nbits_of(len);
    int ones = 0;
    if (!(len >= 5 && len <= 8)) return 1'b0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    return ptype ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  task automatic push_expect(input logic [7:0] d, input logic [3:0] len, input logic pen,
                             input logic ptype, input logic s2, input logic pbit,
                             input logic last_stop, input int unsigned fall);
    exp_t e;
    int n = nbits_of(len);
    int frame_bits = n + int'(pen) + (s2 ? 2 : 1);
    e.data = 8'(int'(d) & ((1 << n) - 1));
    e.perr = pen && (pbit != ref_parity(d, len, ptype));
    e.ferr = ~last_stop;
    e.at   = fall + 2 + frame_bits * OS + OS / 2 + 1;
    sb.push_back(e);
  endtask

  // Must be called #1 after a rising edge; leaves rx at the level of the last stop bit.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input logic pen,
                            input logic ptype, input logic s2, input logic pbit,
                            input logic last_stop, input bit scramble);
    int n = nbits_of(len);
    data_len = len; parity_en = pen; parity_type = ptype; stop2 = s2;
    push_expect(d, len, pen, ptype, s2, pbit, last_stop, cyc);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) begin
      if (scramble && i == 1) begin
        data_len = 4'($urandom); parity_en = 1'($urandom);
        parity_type = 1'($urandom); stop2 = 1'($urandom);
      end
      send_bit(d[i]);
    end
    if (pen) send_bit(pbit);
    if (s2) send_bit(1'b1);
    send_bit(last_stop);
  endtask

  initial begin
    int unsigned f;
    logic [7:0] d;
    logic [3:0] len;
    logic pen, pty, s2, pb;

    hold(3);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_rx_err", rx_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    hold(5);

    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(10);
    send_frame(8'h35, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(10);
    send_frame(8'h35, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(10);
    // unsupported lengths: 8 bits, expected parity 0
    send_frame(8'hFF, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(10);
    send_frame(8'h81, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(10);

    // second stop bit low, line stuck low
    send_frame(8'h66, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(50);
    check("wait_high_busy", rx_busy, 1'b1);
    check("frame_err_held", frame_err, 1'b1);
    hold(50);
    rx = 1'b1;
    hold(10);
    check("wait_high_release", rx_busy, 1'b0);
    hold(10);

    // 4-cycle low glitch
    f = cyc;
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(5);
    check("glitch_busy_high", rx_busy, 1'b1);
    hold(4);
    check("glitch_busy_low", rx_busy, 1'b0);
    hold(40);

`ifdef UART_RX_MAJORITY_EN
    data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    push_expect(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cyc);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0; hold(7);
    rx = 1'b1; hold(1);
    rx = 1'b0; hold(8);
    for (int i = 3; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    hold(10);
`endif

    // reset during data bit 3 of an abandoned frame
    data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b0;
    hold(5);
    rst = 1'b0;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_busy", rx_busy, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_rx_done", rx_done, 1'b0);
    check("midrst_rx_err", rx_err, 1'b0);
    rx = 1'b1;
    hold(3);
    rst = 1'b1;
    hold(30);
    send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // back-to-back 8E2
    send_frame(8'h5A, 4'd8, 1'b1, 1'b1, 1'b1, ref_parity(8'h5A, 4'd8, 1'b1), 1'b1, 1'b0);
    send_frame(8'hC3, 4'd8, 1'b1, 1'b1, 1'b1, ref_parity(8'hC3, 4'd8, 1'b1), 1'b1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 9) < 8) len = 4'(5 + $urandom_range(0, 3));
      else len = 4'($urandom_range(0, 15));
      pen = 1'($urandom); pty = 1'($urandom); s2 = 1'($urandom);
      pb = ref_parity(d, len, pty);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(d, len, pen, pty, s2, pb, 1'b1, 1'b1);
      hold($urandom_range(0, 20));
    end

    for (int t = 0; t < 400 && sb.size() > 0; t++) hold(1);
    hold(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
